// File: rtl/seq_mult_4x4_pkg.sv
// Shared widths, iteration limit and FSM state type for the 4x4 sequential multiplier.
package mult_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  localparam logic [1:0] ITER_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_4x4_adder.sv
// 4-bit ripple-carry adder, the single arithmetic element of the multiplier.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[4];
  end

endmodule

// File: rtl/seq_mult_4x4.sv
// Unsigned 4x4 shift-and-add multiplier: one partial-product add per cycle,
// four iterations, valid/ready handshakes on operand and product sides.
module seq_mult_4x4
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     m_q, m_d;
  logic [OP_W-1:0]     acc_q, acc_d;
  logic [OP_W-1:0]     q_q, q_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [PROD_W-1:0]   product_q, product_d;

  logic [OP_W-1:0]     addB;
  logic [OP_W-1:0]     addSum;
  logic                addCout;

  assign addB = q_q[0] ? m_q : '0;

  four_bit_adder uAdder (
    .a    (acc_q),
    .b    (addB),
    .cin  (1'b0),
    .sum  (addSum),
    .cout (addCout)
  );

  // The carry becomes the top bit of the 9-bit {c,s,q} word before the shift,
  // so the partial sum never loses its overflow bit.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = {addCout, addSum[OP_W-1:1]};
        q_d   = {addSum[0], q_q[OP_W-1:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == ITER_LAST) begin
          product_d = {addCout, addSum[OP_W-1:1], addSum[0], q_q[OP_W-1:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_4x4.sv
// Self-checking bench for seq_mult_4x4 against a plain a*b reference with a product queue.
module tb_seq_mult_4x4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int total;
  int bad;

  seq_mult_4x4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair as soon as in_ready is seen; returns just after the accepting edge.
  task automatic acceptPair(input logic [3:0] x, input logic [3:0] y);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept until out_valid appears; bounded.
  task automatic waitOut(output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busyCycles++;
      step();
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL out_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (product !== 8'h00) begin bad++; $display("[TB] FAIL reset_product: got %h want 00", product); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_max();
    int lat, bc;
    out_ready = 1'b1;
    acceptPair(4'd15, 4'd15);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL max_busy_after_accept: got %b want 1", busy); end
    waitOut(lat, bc);
    total++; if (lat != 4) begin bad++; $display("[TB] FAIL max_latency: got %0d want 4", lat); end
    total++; if (bc != 4) begin bad++; $display("[TB] FAIL max_busy_cycles: got %0d want 4", bc); end
    total++; if (product !== 8'(15 * 15)) begin bad++; $display("[TB] FAIL max_product: got %h want e1", product); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL max_out_drop: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL max_back_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [3:0] xs [2];
    logic [3:0] ys [2];
    xs[0] = 4'd0; ys[0] = 4'd9;
    xs[1] = 4'd9; ys[1] = 4'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      acceptPair(xs[i], ys[i]);
      waitOut(lat, bc);
      total++; if (lat != 4) begin bad++; $display("[TB] FAIL zero_latency[%0d]: got %0d want 4", i, lat); end
      total++; if (product !== 8'h00) begin bad++; $display("[TB] FAIL zero_product[%0d]: got %h want 00", i, product); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    out_ready = 1'b0;
    acceptPair(4'd3, 4'd5);
    waitOut(lat, bc);
    for (int i = 0; i < 3; i++) begin
      total++; if (product !== 8'h0F) begin bad++; $display("[TB] FAIL bp_product[%0d]: got %h want 0f", i, product); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      step();
    end
    total++; if (product !== 8'h0F) begin bad++; $display("[TB] FAIL bp_product_final: got %h want 0f", product); end
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_out_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_ignore_input();
    int guard = 0;
    out_ready = 1'b0;
    acceptPair(4'd7, 4'd6);
    a = 4'd1;
    b = 4'd1;
    in_valid = 1'b1;
    while (!out_valid && guard < 20) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ign_in_ready_busy: got %b want 0", in_ready); end
      step();
      guard++;
    end
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ign_in_ready_done: got %b want 0", in_ready); end
    total++; if (product !== 8'(7 * 6)) begin bad++; $display("[TB] FAIL ign_product: got %h want 2a", product); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ign_back_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    out_ready = 1'b1;
    acceptPair(4'd12, 4'd11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_out_valid: got %b want 0", out_valid); end
    total++; if (product !== 8'h00) begin bad++; $display("[TB] FAIL abort_product: got %h want 00", product); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    acceptPair(4'd2, 4'd3);
    waitOut(lat, bc);
    total++; if (product !== 8'h06) begin bad++; $display("[TB] FAIL abort_next_product: got %h want 06", product); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] expQ [$];
    logic [7:0] exp;
    int inCount = 0;
    int outCount = 0;
    int lat, bc;
    int stall;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] x, y;
      x = 4'(i >> 4);
      y = 4'(i);
      out_ready = 1'b0;
      acceptPair(x, y);
      expQ.push_back(8'(int'(x) * int'(y)));
      inCount++;
      waitOut(lat, bc);
      stall = int'($urandom_range(0, 2));
      for (int s = 0; s < stall; s++) step();
      exp = expQ.pop_front();
      total++;
      if (product !== exp) begin
        bad++;
        $display("[TB] FAIL sweep_product a=%0d b=%0d: got %h want %h", x, y, product, exp);
      end
      out_ready = 1'b1;
      step();
      outCount++;
    end
    total++;
    if (inCount != outCount || expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL sweep_count: in=%0d out=%0d left=%0d", inCount, outCount, expQ.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_max();
    test_zero();
    test_backpressure();
    test_ignore_input();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
